// File: rtl/immgen_pkg.sv
// Shared definitions for the decode-stage immediate generator: the select
// encoding and the format decode used by immgen_pipe.
package immgen_pkg;

    localparam int IMM_SEL_W = 3;

    // Codes 0..4 keep the numbering the older immediate defines used.
    typedef enum logic [IMM_SEL_W-1:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_SH   = 3'd6,
        IMM_RSVD = 3'd7
    } imm_sel_e;

    // Decode instr[31:7] into a 64-bit immediate plus an illegal flag in
    // bit 64. Every format is extended to 64 bits, so the low xlen bits are
    // exactly the XLEN-wide result; xlen only matters for the shift amount.
    function automatic logic [64:0] imm_decode(
        input logic [24:0]          instr,
        input logic [IMM_SEL_W-1:0] sel,
        input int unsigned          xlen
    );
        logic [31:0] f;
        logic [63:0] imm;
        logic        illegal;
        f       = {instr, 7'b0};
        imm     = '0;
        illegal = 1'b0;
        case (imm_sel_e'(sel))
            IMM_I:  imm = {{52{f[31]}}, f[31:20]};
            IMM_S:  imm = {{52{f[31]}}, f[31:25], f[11:7]};
            IMM_B:  imm = {{51{f[31]}}, f[31], f[7], f[30:25], f[11:8], 1'b0};
            IMM_U:  imm = {{32{f[31]}}, f[31:12], 12'b0};
            IMM_J:  imm = {{43{f[31]}}, f[31], f[19:12], f[20], f[30:21], 1'b0};
            IMM_Z:  imm = {59'b0, f[19:15]};
            IMM_SH: imm = (xlen == 64) ? {58'b0, f[25:20]} : {59'b0, f[24:20]};
            default: begin
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
        return {illegal, imm};
    endfunction

endpackage

// File: rtl/immgen_pipe_skid_buffer.sv
// Generic 2-entry valid/ready register slice. The output register feeds the
// consumer; the skid entry catches the one transfer that arrives while the
// output is stalled, so in_ready comes straight from a flop.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer side never depends on out_ready combinationally; payload and
// out_valid hold steady while out_valid && !out_ready. flush empties both
// entries on the next edge and drops whatever is offered that cycle.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         fire;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid;
    assign fire     = out_valid & out_ready;

    // Move entries skid -> output -> consumer in FIFO order; flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || fire) begin
            if (skid_valid) begin
                // skid_valid blocks accept, so nothing new arrives here
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/immgen_pipe.sv
// Registered immediate generator for the decode stage. The immediate is
// decoded combinationally from the incoming instruction and then carried,
// with its tag and illegal flag, through a 2-entry skid buffer.
module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int XLEN  = 32,  // 32 or 64
    parameter int TAG_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [24:0]          instr,
    input  logic [IMM_SEL_W-1:0] imm_sel,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      imm_out,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_illegal
);

    localparam int W = XLEN + TAG_W + 1;

    logic [64:0]  dec;
    logic [W-1:0] in_data;
    logic [W-1:0] out_data;

    // Decode the incoming instruction before it is registered.
    always_comb begin
        dec = imm_decode(instr, imm_sel, XLEN);
    end

    // Upper decode bits are pure sign/zero extension when XLEN is 32.
    if (XLEN < 64) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^dec[63:XLEN];
    end

    assign in_data = {dec[64], in_tag, dec[XLEN-1:0]};

    skid_buffer #(
        .W(W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign imm_out     = out_data[XLEN-1:0];
    assign out_tag     = out_data[XLEN+TAG_W-1:XLEN];
    assign out_illegal = out_data[W-1];

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: a 32-bit and a 64-bit instance share stimulus so
// both widths are checked against one reference model and scoreboard.
module tb_immgen_pipe;

    localparam int EW = 1 + 32 + 64 + 32;  // {illegal, tag, imm64, imm32}

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [24:0] instr;
    logic [2:0]  imm_sel;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tag32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    int tests = 0;
    int fails = 0;

    logic [EW-1:0] exp_q[$];
    logic          prev_stall = 1'b0;
    logic [31:0]   prev_imm32, prev_tag32;
    logic [63:0]   prev_imm64;
    logic          prev_ill32, prev_ill64;

    immgen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready32), .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .imm_out(imm32),
        .out_tag(tag32), .out_illegal(ill32)
    );

    immgen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready64), .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .imm_out(imm64),
        .out_tag(tag64), .out_illegal(ill64)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Reference: field arithmetic on a 64-bit signed view of the instruction.
    function automatic logic [64:0] ref_imm(input logic [31:0] full, input logic [2:0] sel,
                                            input bit x64);
        longint s, u, v;
        bit ill;
        s = longint'($signed(full));
        u = longint'({32'b0, full});
        v = 0;
        ill = 1'b0;
        case (sel)
            3'd0: v = s >>> 20;
            3'd1: v = ((s >>> 25) <<< 5) | ((u >> 7) & 31);
            3'd2: v = ((s >>> 31) <<< 12) | (((u >> 7) & 1) << 11)
                    | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
            3'd3: v = (s >>> 12) <<< 12;
            3'd4: v = ((s >>> 31) <<< 20) | (((u >> 12) & 255) << 12)
                    | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
            3'd5: v = (u >> 15) & 31;
            3'd6: v = x64 ? ((u >> 20) & 63) : ((u >> 20) & 31);
            default: ill = 1'b1;
        endcase
        return {ill, v};
    endfunction

    function automatic logic [EW-1:0] make_exp(input logic [24:0] ins, input logic [2:0] sel,
                                               input logic [31:0] tag);
        logic [31:0] full;
        logic [64:0] r64, r32;
        full = {ins, 7'b0};
        r64  = ref_imm(full, sel, 1'b1);
        r32  = ref_imm(full, sel, 1'b0);
        return {r64[64], tag, r64[63:0], r32[31:0]};
    endfunction

    // scoreboard: occupancy, ordering, stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            logic [EW-1:0] e;
            chk("out_valid32_occ", {63'b0, out_valid32}, {63'b0, exp_q.size() > 0});
            chk("out_valid64_occ", {63'b0, out_valid64}, {63'b0, exp_q.size() > 0});
            chk("in_ready32_occ", {63'b0, in_ready32}, {63'b0, exp_q.size() < 2});
            chk("in_ready64_occ", {63'b0, in_ready64}, {63'b0, exp_q.size() < 2});
            if (prev_stall) begin
                chk("stall_imm32", {32'b0, imm32}, {32'b0, prev_imm32});
                chk("stall_imm64", imm64, prev_imm64);
                chk("stall_tag", {32'b0, tag32}, {32'b0, prev_tag32});
                chk("stall_ill", {62'b0, ill32, ill64}, {62'b0, prev_ill32, prev_ill64});
            end
            if (out_valid32 && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_imm32", {32'b0, imm32}, {32'b0, e[31:0]});
                chk("sb_imm64", imm64, e[95:32]);
                chk("sb_tag32", {32'b0, tag32}, {32'b0, e[127:96]});
                chk("sb_tag64", {32'b0, tag64}, {32'b0, e[127:96]});
                chk("sb_ill32", {63'b0, ill32}, {63'b0, e[128]});
                chk("sb_ill64", {63'b0, ill64}, {63'b0, e[128]});
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready32) exp_q.push_back(make_exp(instr, imm_sel, in_tag));
            prev_stall = out_valid32 && !out_ready && !flush;
            prev_imm32 = imm32;
            prev_imm64 = imm64;
            prev_tag32 = tag32;
            prev_ill32 = ill32;
            prev_ill64 = ill64;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // driver tasks
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready32 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {63'b0, in_ready32}, 64'd1);
    endtask

    task automatic send(input logic [31:0] full, input logic [2:0] sel, input logic [31:0] tag);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        instr    = full[31:7];
        imm_sel  = sel;
        in_tag   = tag;
        wait_ready();
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [31:0] e32, input logic [63:0] e64,
                              input logic [31:0] etag, input logic eill);
        chk({name, "_valid"}, {62'b0, out_valid32, out_valid64}, 64'd3);
        chk({name, "_imm32"}, {32'b0, imm32}, {32'b0, e32});
        chk({name, "_imm64"}, imm64, e64);
        chk({name, "_tag"}, {tag32, tag64}, {etag, etag});
        chk({name, "_ill"}, {62'b0, ill32, ill64}, {62'b0, eill, eill});
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0;
        imm_sel = '0; in_tag = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {62'b0, out_valid32, out_valid64}, 64'd0);
        chk("rst_in_ready", {62'b0, in_ready32, in_ready64}, 64'd3);
        chk("rst_imm", imm64 | {32'b0, imm32}, 64'd0);
        chk("rst_tag_ill", {tag32, tag64} | {62'b0, ill32, ill64}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // formats, back-to-back with out_ready high
        send(32'h00100093, 3'd0, 32'h100);
        send(32'h00102123, 3'd1, 32'h101);
        expect_out("addi", 32'h1, 64'h1, 32'h100, 1'b0);
        send(32'hFE000EE3, 3'd2, 32'h102);
        expect_out("sw", 32'h2, 64'h2, 32'h101, 1'b0);
        send(32'h00001097, 3'd3, 32'h103);
        expect_out("beq", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 32'h102, 1'b0);
        send(32'h008000EF, 3'd4, 32'h104);
        expect_out("auipc", 32'h1000, 64'h1000, 32'h103, 1'b0);
        send(32'hFFF00093, 3'd0, 32'h105);
        expect_out("jal", 32'h8, 64'h8, 32'h104, 1'b0);
        send(32'h800000B7, 3'd3, 32'h106);
        expect_out("i_neg", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'h105, 1'b0);
        send(32'h03F00000, 3'd6, 32'h107);
        expect_out("u_neg", 32'h80000000, 64'hFFFFFFFF80000000, 32'h106, 1'b0);
        send(32'h3402D0F3, 3'd5, 32'h108);
        expect_out("sh", 32'h1F, 64'h3F, 32'h107, 1'b0);
        send(32'hFFFFFFFF, 3'd7, 32'h109);
        expect_out("csr_z", 32'h5, 64'h5, 32'h108, 1'b0);
        idle();
        expect_out("rsvd", 32'h0, 64'h0, 32'h109, 1'b1);
        idle();

        // backpressure: A in output, B in skid, C held
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 32'hA);
        send(32'h00102123, 3'd1, 32'hB);
        @(posedge clk);
        #1;
        instr = 25'(32'hFE000EE3 >> 7); imm_sel = 3'd2; in_tag = 32'hC;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {62'b0, in_ready32, in_ready64}, 64'd0);
            expect_out("bp_hold_a", 32'h1, 64'h1, 32'hA, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        expect_out("bp_a", 32'h1, 64'h1, 32'hA, 1'b0);
        @(negedge clk);
        expect_out("bp_b", 32'h2, 64'h2, 32'hB, 1'b0);
        chk("bp_ready_back", {63'b0, in_ready32}, 64'd1);
        idle();
        expect_out("bp_c", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 32'hC, 1'b0);
        idle();
        chk("bp_drained", {62'b0, out_valid32, out_valid64}, 64'd0);

        // flush with both entries full, then with only the output full
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b0;
            send(32'h00100093, 3'd0, 32'hA0 + k);
            if (k == 0) send(32'h00102123, 3'd1, 32'hB0);
            @(posedge clk);
            #1;
            flush = 1'b1; in_valid = 1'b1; in_tag = 32'hD0 + k;
            instr = 25'(32'h00001097 >> 7); imm_sel = 3'd3;
            @(negedge clk);
            idle();
            chk("flush_out_valid", {62'b0, out_valid32, out_valid64}, 64'd0);
            chk("flush_in_ready", {62'b0, in_ready32, in_ready64}, 64'd3);
            out_ready = 1'b1;
            repeat (3) begin
                idle();
                chk("flush_no_d", {63'b0, out_valid32}, 64'd0);
            end
        end

        // asynchronous reset while holding a valid output
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 32'hE);
        idle();
        chk("pre_rst_valid", {63'b0, out_valid32}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {62'b0, out_valid32, out_valid64}, 64'd0);
        chk("arst_imm", imm64 | {32'b0, imm32}, 64'd0);
        chk("arst_in_ready", {62'b0, in_ready32, in_ready64}, 64'd3);
        exp_q.delete();
        prev_stall = 1'b0;
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h008000EF, 3'd4, 32'hF);
        idle();
        expect_out("post_rst", 32'h8, 64'h8, 32'hF, 1'b0);

        // randomized traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = 25'($urandom);
            imm_sel   = 3'($urandom_range(0, 7));
            in_tag    = $urandom;
            out_ready = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 50) == 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
